ring_seq: RTL and testbench
===========================

Name: ring_seq

Overview:
- Parametrised one-hot phase sequencer for the multicore count-up pipeline. It generalises the fixed 4-phase start/stop ring to N phases.
- Adds free-run and burst modes, hold, synchronous load, a rotation counter, a done pulse and illegal-state recovery.
- Drives per-core/per-stage enables; q[k] high = phase k active, q all-zero = idle.

Parameters:
- N, 4, number of phases (q width), N >= 2
- CW, 8, width of burst length and rotation counter
- RST_Q, {{N-1{1'b0}},1'b0}, value q takes on reset (zero or one-hot; default idle)

Ports:
- CLK  input  1  clock, rising edge
- RSTN  input  1  asynchronous active-low reset
- start  input  1  begin sequencing when idle
- stop  input  1  request stop at end of current rotation
- hold  input  1  freeze q while running
- mode  input  1  0 = free run, 1 = burst
- burst_len  input  CW  rotations per burst (0 treated as 1)
- load  input  1  synchronous load of d into q
- d  input  N  load value
- q  output  N  one-hot phase vector, zero = idle
- busy  output  1  q != 0
- done  output  1  one-cycle pulse on last-phase -> idle transition
- cycles  output  CW  rotations completed in current run, saturating
- err  output  1  sticky illegal-state flag

Behaviour:
- Reset (RSTN=0, async): q=RST_Q, stop_req=0, cycles=0, done=0, err=0. Reset mid-run aborts immediately with no done pulse.
- Per-edge priority: load > illegal-state recovery > idle/run logic.
- load=1: q<=d, stop_req<=0, cycles<=0, err<=0, done<=0. No legality check that cycle.
- Illegal: popcount(q)>1 -> q<=0, err<=1 (sticky until load/reset), stop_req<=0, done stays 0.
- Idle (q==0):
  - start=1 -> q<=one-hot bit 0, cycles<=0, stop_req<=0.
  - Otherwise q stays 0.
  - stop and hold are ignored while idle.
- Run (q one-hot, not last phase):
  - hold=0 -> q rotates left one position.
  - hold=1 -> q unchanged.
- Run, last phase (q[N-1]=1, hold=0):
  - end = stop | stop_req | (mode & (cycles+1 >= max(burst_len,1))).
  - end -> q<=0, done<=1, stop_req<=0.
  - otherwise -> q<=bit 0.
  - cycles<=cycles+1 in both cases, saturating at 2^CW-1.
- Last phase with hold=1: no advance, no count, no end.
- stop_req: set when stop=1 while busy (including during hold); it takes effect at the next last-phase advance. stop in the same cycle as a last-phase advance ends the run on that edge.
- start while busy: ignored. start together with load: load wins.
- mode and burst_len are sampled at every last-phase evaluation. Changing them mid-run takes effect at the next wrap.
- Timing:
  - done is registered: high exactly the cycle q first reads 0 after a run, low otherwise.
  - busy is combinational from q.
  - Latency start -> q=bit 0 is 1 edge. One rotation takes N edges.
- Free run with no stop: rotates indefinitely, cycles saturates, no done.

Test Plan:
- Reset with RST_Q=0, N=4; pulse start -> q sequence 0001,0010,0100,1000,0001…, busy=1 from edge 1, cycles increments on each 1000->0001.
- Free run, stop pulsed 1 cycle while q=0010 -> run continues to 1000, then q=0000, done=1 for exactly one cycle, cycles=final rotation count.
- mode=1, burst_len=3, start -> exactly 12 active cycles, q=0 after third 1000, done pulse, cycles=3; burst_len=0 -> one rotation only.
- hold asserted 5 cycles at q=0100 -> q stays 0100, cycles unchanged; stop asserted during hold, then hold released -> stops at end of that rotation.
- load d=0101 -> next edge q=0000, err=1; start -> normal run with err still 1; load d=0010 -> q=0010, err=0, continues rotating.
- Assert RSTN low mid-run at q=0100 -> q=RST_Q immediately (asynchronous), done=0, cycles=0; N=8, CW=3 instance: free run 9 rotations -> cycles saturates at 7.

Source files
------------

// File: rtl/ring_seq.sv
// One-hot N-phase ring sequencer with free-run/burst modes, hold, load,
// saturating rotation counter, done pulse and illegal-state recovery.
module ring_seq #(
    parameter int             N     = 4,
    parameter int             CW    = 8,
    parameter logic [N-1:0]   RST_Q = '0
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          start,
    input  logic          stop,
    input  logic          hold,
    input  logic          mode,
    input  logic [CW-1:0] burst_len,
    input  logic          load,
    input  logic [N-1:0]  d,
    output logic [N-1:0]  q,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cycles,
    output logic          err
);

    localparam logic [N-1:0]  PH0    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   CNT1   = {{CW{1'b0}}, 1'b1};

    logic          stop_req;
    logic          multi_hot;
    logic          last_phase;
    logic [CW:0]   cyc_next;
    logic [CW:0]   blen_eff;
    logic [CW-1:0] cyc_sat;
    logic          burst_end;
    logic          run_end;

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign multi_hot  = (q & (q - PH0)) != '0;
    assign last_phase = q[N-1];
    assign busy       = q != '0;

    assign cyc_next  = {1'b0, cycles} + CNT1;
    assign cyc_sat   = cyc_next[CW] ? cycles : cyc_next[CW-1:0];
    assign blen_eff  = (burst_len == '0) ? CNT1 : {1'b0, burst_len};
    assign burst_end = mode && (cyc_next >= blen_eff);
    assign run_end   = stop || stop_req || burst_end;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            q        <= RST_Q;
            stop_req <= 1'b0;
            cycles   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                q        <= d;
                stop_req <= 1'b0;
                cycles   <= '0;
                err      <= 1'b0;
            end else if (multi_hot) begin
                q        <= '0;
                err      <= 1'b1;
                stop_req <= 1'b0;
            end else if (q == '0) begin
                if (start) begin
                    q        <= PH0;
                    cycles   <= '0;
                    stop_req <= 1'b0;
                end
            end else if (hold) begin
                if (stop) stop_req <= 1'b1;
            end else if (!last_phase) begin
                q <= {q[N-2:0], 1'b0};
                if (stop) stop_req <= 1'b1;
            end else begin
                // Wrap point: the only place the counter advances and a run may end.
                cycles <= cyc_sat;
                if (run_end) begin
                    q        <= '0;
                    done     <= 1'b1;
                    stop_req <= 1'b0;
                end else begin
                    q <= PH0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ring_seq.sv
// Bench for ring_seq: directed scenarios with spec-derived constants plus a
// randomized run checked against a phase-index reference model.
module tb_ring_seq;

    localparam int N   = 4;
    localparam int CW  = 8;
    localparam int NB  = 8;
    localparam int CWB = 3;
    localparam logic [N-1:0] P0 = {{(N-1){1'b0}}, 1'b1};

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          start, stop, hold, mode, load;
    logic [CW-1:0] burst_len;
    logic [N-1:0]  d;
    logic [N-1:0]  q;
    logic          busy, done, err;
    logic [CW-1:0] cycles;

    logic           b_start;
    logic [NB-1:0]  b_q;
    logic           b_busy, b_done, b_err;
    logic [CWB-1:0] b_cycles;

    int n_pass  = 0;
    int n_total = 0;

    logic [N-1:0] m_q;
    logic         m_sreq, m_done, m_err;
    int           m_cyc;

    ring_seq #(.N(N), .CW(CW)) dut (
        .CLK(CLK), .RSTN(RSTN), .start(start), .stop(stop), .hold(hold),
        .mode(mode), .burst_len(burst_len), .load(load), .d(d),
        .q(q), .busy(busy), .done(done), .cycles(cycles), .err(err)
    );

    ring_seq #(.N(NB), .CW(CWB)) dut_b (
        .CLK(CLK), .RSTN(RSTN), .start(b_start), .stop(1'b0), .hold(1'b0),
        .mode(1'b0), .burst_len(3'd0), .load(1'b0), .d(8'd0),
        .q(b_q), .busy(b_busy), .done(b_done), .cycles(b_cycles), .err(b_err)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_q    = '0;
        m_sreq = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_cyc  = 0;
    endtask

    // Reference: find the active phase index and apply the sequencing rules.
    task automatic model_step();
        int ph;
        int blen;
        bit fin;
        m_done = 1'b0;
        if (load) begin
            m_q = d; m_sreq = 1'b0; m_cyc = 0; m_err = 1'b0;
        end else if ($countones(m_q) > 1) begin
            m_q = '0; m_err = 1'b1; m_sreq = 1'b0;
        end else if (m_q == '0) begin
            if (start) begin
                m_q = P0; m_cyc = 0; m_sreq = 1'b0;
            end
        end else begin
            ph = 0;
            for (int k = 0; k < N; k++) if (m_q[k]) ph = k;
            if (hold) begin
                m_sreq = m_sreq | stop;
            end else if (ph < N - 1) begin
                m_q = '0;
                m_q[ph + 1] = 1'b1;
                m_sreq = m_sreq | stop;
            end else begin
                blen = (burst_len == '0) ? 1 : int'(burst_len);
                fin = stop || m_sreq || (mode && (m_cyc + 1 >= blen));
                m_cyc = (m_cyc + 1 > (2 ** CW) - 1) ? (2 ** CW) - 1 : m_cyc + 1;
                m_q = fin ? '0 : P0;
                m_done = fin;
                if (fin) m_sreq = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (!RSTN) model_reset();
        else model_step();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0;
        burst_len = '0; load = 1'b0; d = '0; b_start = 1'b0;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) tick();
        RSTN = 1'b1;
        tick();
        n_total++;
        if (q !== '0 || busy !== 1'b0) $display("FAIL reset_q: got q=%b busy=%b want q=0000 busy=0", q, busy);
        else n_pass++;
        n_total++;
        if (done !== 1'b0 || err !== 1'b0 || cycles !== '0)
            $display("FAIL reset_flags: got done=%b err=%b cycles=%0d want 0/0/0", done, err, cycles);
        else n_pass++;
    endtask

    task automatic test_free_run();
        logic [N-1:0] exp_q;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            exp_q = P0 << (k % N);
            n_total++;
            if (q !== exp_q || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL free_run_seq step %0d: got q=%b busy=%b done=%b want q=%b busy=1 done=0", k, q, busy, done, exp_q);
            else n_pass++;
            n_total++;
            if (cycles !== CW'(k / N))
                $display("FAIL free_run_cycles step %0d: got %0d want %0d", k, cycles, k / N);
            else n_pass++;
            tick();
        end
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        n_total++;
        if (q !== 4'b0100) $display("FAIL stop_continues: got q=%b want 0100", q);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (q !== '0 || done !== 1'b1 || cycles !== 8'd4)
            $display("FAIL stop_end: got q=%b done=%b cycles=%0d want 0000/1/4", q, done, cycles);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0 || q !== '0) $display("FAIL done_one_cycle: got done=%b q=%b want 0/0000", done, q);
        else n_pass++;
    endtask

    task automatic test_burst();
        int active;
        int exp_rot;
        for (int c = 0; c < 2; c++) begin
            mode = 1'b1;
            burst_len = (c == 0) ? 8'd3 : 8'd0;
            exp_rot = (c == 0) ? 3 : 1;
            start = 1'b1; tick(); start = 1'b0;
            active = 0;
            for (int i = 0; i < 20; i++) begin
                if (q == '0) break;
                active++;
                tick();
            end
            n_total++;
            if (active !== exp_rot * N) $display("FAIL burst_active len=%0d: got %0d want %0d", burst_len, active, exp_rot * N);
            else n_pass++;
            n_total++;
            if (done !== 1'b1 || cycles !== CW'(exp_rot))
                $display("FAIL burst_end len=%0d: got done=%b cycles=%0d want 1/%0d", burst_len, done, cycles, exp_rot);
            else n_pass++;
            tick();
        end
        mode = 1'b0; burst_len = '0;
    endtask

    task automatic test_hold();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stop = (i == 2);
            tick();
            n_total++;
            if (q !== 4'b0100 || cycles !== '0 || busy !== 1'b1)
                $display("FAIL hold_freeze %0d: got q=%b cycles=%0d want 0100/0", i, q, cycles);
            else n_pass++;
        end
        hold = 1'b0; stop = 1'b0;
        tick();
        n_total++;
        if (q !== 4'b1000) $display("FAIL hold_release: got q=%b want 1000", q);
        else n_pass++;
        tick();
        n_total++;
        if (q !== '0 || done !== 1'b1 || cycles !== 8'd1)
            $display("FAIL hold_stop_end: got q=%b done=%b cycles=%0d want 0000/1/1", q, done, cycles);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_err();
        load = 1'b1; d = 4'b0101; tick(); load = 1'b0;
        n_total++;
        if (q !== 4'b0101 || err !== 1'b0) $display("FAIL load_raw: got q=%b err=%b want 0101/0", q, err);
        else n_pass++;
        tick();
        n_total++;
        if (q !== '0 || err !== 1'b1 || done !== 1'b0)
            $display("FAIL illegal_recover: got q=%b err=%b done=%b want 0000/1/0", q, err, done);
        else n_pass++;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        n_total++;
        if (q !== 4'b0010 || err !== 1'b1) $display("FAIL err_sticky: got q=%b err=%b want 0010/1", q, err);
        else n_pass++;
        load = 1'b1; d = 4'b0010; tick(); load = 1'b0;
        n_total++;
        if (q !== 4'b0010 || err !== 1'b0 || cycles !== '0)
            $display("FAIL load_clear: got q=%b err=%b cycles=%0d want 0010/0/0", q, err, cycles);
        else n_pass++;
        tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0;
        n_total++;
        if (q !== '0 || done !== 1'b1 || cycles !== 8'd1)
            $display("FAIL stop_at_last: got q=%b done=%b cycles=%0d want 0000/1/1", q, done, cycles);
        else n_pass++;
        load = 1'b1; start = 1'b1; d = 4'b0000; tick(); load = 1'b0; start = 1'b0;
        n_total++;
        if (q !== '0 || cycles !== '0) $display("FAIL load_beats_start: got q=%b cycles=%0d want 0000/0", q, cycles);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int exp_c;
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int r = 1; r <= 9; r++) begin
            repeat (NB) tick();
            exp_c = (r > 7) ? 7 : r;
            n_total++;
            if (b_cycles !== CWB'(exp_c) || b_q !== 8'b0000_0001 || b_done !== 1'b0)
                $display("FAIL saturate rot %0d: got cycles=%0d q=%b done=%b want %0d/00000001/0", r, b_cycles, b_q, b_done, exp_c);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1; tick(); start = 1'b0;
        repeat (N + 2) tick();
        n_total++;
        if (q !== 4'b0100 || cycles !== 8'd1) $display("FAIL pre_reset: got q=%b cycles=%0d want 0100/1", q, cycles);
        else n_pass++;
        #2 RSTN = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || cycles !== '0)
            $display("FAIL async_reset: got q=%b busy=%b done=%b cycles=%0d want 0000/0/0/0", q, busy, done, cycles);
        else n_pass++;
        tick();
        RSTN = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [N+CW+2:0] got, exp;
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 7) == 0);
            hold      = ($urandom_range(0, 3) == 0);
            mode      = 1'($urandom_range(0, 1));
            burst_len = CW'($urandom_range(0, 3));
            load      = ($urandom_range(0, 19) == 0);
            d         = N'($urandom_range(0, 15));
            tick();
            got = {q, busy, done, cycles, err};
            exp = {m_q, m_q != '0, m_done, m_cyc[CW-1:0], m_err};
            n_total++;
            if (got !== exp)
                $display("FAIL random cyc %0d: got q=%b busy=%b done=%b cycles=%0d err=%b want q=%b busy=%b done=%b cycles=%0d err=%b",
                         i, q, busy, done, cycles, err, m_q, m_q != '0, m_done, m_cyc, m_err);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_burst();
        test_hold();
        test_load_err();
        test_saturate();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
